// File: rtl/prach_pkg.sv
// Shared widths, defaults and lock state type for the PRACH channel reshape/unshape path.
package prach_pkg;

    localparam int unsigned SampleWidth  = 16;
    localparam int unsigned ChnWidth     = 8;
    localparam int unsigned NumChDefault = 48;

    typedef enum logic {
        StUnlocked,
        StLocked
    } lock_state_t;

endpackage

// File: rtl/delay.sv
// Fixed-length shift-register delay line; reset clears contents (tie rst_n high when not needed).
module delay #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DELAY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr [DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DELAY); i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= din;
            for (int i = 1; i < int'(DELAY); i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DELAY-1];

endmodule

// File: rtl/prach_unshape_ch.sv
// Undoes the PRACH lane reshape: 2x2 transpose of H-cycle half-blocks over each 2H-cycle period,
// with channel gating and a lock that holds dout_dv low until the first synced sample arrives.
module prach_unshape_ch
    import prach_pkg::*;
#(
    parameter int unsigned SIZE   = 8,
    parameter int unsigned NUM_CH = NumChDefault
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SampleWidth-1:0] din_dp1,
    input  logic [SampleWidth-1:0] din_dp2,
    input  logic                   din_dv,
    input  logic [ChnWidth-1:0]    din_chn,
    input  logic                   sync_in,
    output logic [SampleWidth-1:0] dout_dq1,
    output logic [SampleWidth-1:0] dout_dq2,
    output logic                   dout_dv,
    output logic [ChnWidth-1:0]    dout_chn,
    output logic                   sync_out,
    output logic                   sync_err
);

    localparam int unsigned H     = SIZE / 2;
    localparam int unsigned PW    = $clog2(SIZE);
    localparam int unsigned CtrlW = ChnWidth + 2;

    logic [PW-1:0]          ph;
    logic [PW-1:0]          pe;
    logic                   h;
    logic [SampleWidth-1:0] d1;
    logic [SampleWidth-1:0] d2a;
    logic [SampleWidth-1:0] d2b;
    logic [CtrlW-1:0]       ctrl_d;
    logic                   dv_d;
    lock_state_t            state;
    logic                   lock_now;
    logic [H:0]             lock_pipe;
    logic                   locked;

    assign pe = sync_in ? '0 : ph;
    assign h  = pe[PW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= '0;
        end else begin
            ph <= pe + 1'b1;
        end
    end

    // Data lines carry no reset: their contents are masked by the lock until refilled.
    delay #(.WIDTH(SampleWidth), .DELAY(H)) u_d1 (
        .clk   (clk),
        .rst_n (1'b1),
        .din   (din_dp1),
        .dout  (d1)
    );

    delay #(.WIDTH(SampleWidth), .DELAY(H)) u_d2a (
        .clk   (clk),
        .rst_n (1'b1),
        .din   (din_dp2),
        .dout  (d2a)
    );

    delay #(.WIDTH(SampleWidth), .DELAY(H)) u_d2b (
        .clk   (clk),
        .rst_n (1'b1),
        .din   (d2a),
        .dout  (d2b)
    );

    delay #(.WIDTH(CtrlW), .DELAY(H)) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({sync_in, din_chn, din_dv}),
        .dout  (ctrl_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_dq1 <= '0;
            dout_dq2 <= '0;
            sync_out <= 1'b0;
            dout_chn <= '0;
            dv_d     <= 1'b0;
        end else begin
            if (h) begin
                dout_dq1 <= d1;
                dout_dq2 <= din_dp1;
            end else begin
                dout_dq1 <= d2b;
                dout_dq2 <= d2a;
            end
            {sync_out, dout_chn, dv_d} <= ctrl_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StUnlocked;
            sync_err <= 1'b0;
        end else begin
            case (state)
                StUnlocked: if (sync_in) state <= StLocked;
                StLocked:   state <= StLocked;
                default:    state <= StUnlocked;
            endcase
            // A sync at ph=0 is the natural wrap and is legal.
            if (sync_in && (ph != '0) && (state == StLocked)) begin
                sync_err <= 1'b1;
            end
        end
    end

    // Lock travels alongside the data so dv opens exactly with the first synced sample.
    assign lock_now = (state == StLocked) || sync_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_pipe <= '0;
        end else begin
            lock_pipe <= {lock_pipe[H-1:0], lock_now};
        end
    end

    assign locked  = lock_pipe[H];
    assign dout_dv = dv_d && (32'(dout_chn) < NUM_CH) && locked;

endmodule

// File: tb/tb_prach_unshape_ch.sv
// Directed bench for prach_unshape_ch: periods are built in original order, reshaped here and the
// originals are queued as the expected output stream.
module tb_prach_unshape_ch;

    localparam int SIZE = 8;
    localparam int H    = SIZE / 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] din_dp1 = '0;
    logic [15:0] din_dp2 = '0;
    logic        din_dv  = 1'b0;
    logic [7:0]  din_chn = '0;
    logic        sync_in = 1'b0;
    logic [15:0] dout_dq1;
    logic [15:0] dout_dq2;
    logic        dout_dv;
    logic [7:0]  dout_chn;
    logic        sync_out;
    logic        sync_err;

    always #5 clk = ~clk;

    prach_unshape_ch #(.SIZE(SIZE), .NUM_CH(48)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_dp1  (din_dp1),
        .din_dp2  (din_dp2),
        .din_dv   (din_dv),
        .din_chn  (din_chn),
        .sync_in  (sync_in),
        .dout_dq1 (dout_dq1),
        .dout_dq2 (dout_dq2),
        .dout_dv  (dout_dv),
        .dout_chn (dout_chn),
        .sync_out (sync_out),
        .sync_err (sync_err)
    );

    typedef struct {
        int          due;
        logic [15:0] q1;
        logic [15:0] q2;
        logic [7:0]  chn;
        logic        dv;
        logic        so;
    } exp_t;

    exp_t        sb[$];
    int          cyc      = 0;
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] p1 [SIZE];
    logic [15:0] p2 [SIZE];
    logic [7:0]  pc [SIZE];
    logic        pv [SIZE];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Drive one cycle, sample #1 after the edge, retire any expectations due now.
    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [7:0] chn,
                        input logic dv, input logic sy);
        exp_t e;
        din_dp1 = a;
        din_dp2 = b;
        din_chn = chn;
        din_dv  = dv;
        sync_in = sy;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("dq1", 32'(dout_dq1), 32'(e.q1));
            check("dq2", 32'(dout_dq2), 32'(e.q2));
            check("chn", 32'(dout_chn), 32'(e.chn));
            check("dv", 32'(dout_dv), 32'(e.dv));
            check("sync_out", 32'(sync_out), 32'(e.so));
        end
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step(16'h0, 16'h0, 8'h0, 1'b0, 1'b0);
    endtask

    // p1/p2 hold the period in original order; reshape to [A1,A2]/[B1,B2] and queue originals.
    task automatic run_period(input bit quiet);
        logic [15:0] r1;
        logic [15:0] r2;
        exp_t        e;
        for (int k = 0; k < SIZE; k++) begin
            r1    = (k < H) ? p1[k] : p2[k-H];
            r2    = (k < H) ? p1[k+H] : p2[k];
            e.due = cyc + H + 1;
            e.q1  = p1[k];
            e.q2  = p2[k];
            e.chn = pc[k];
            e.dv  = pv[k] && (pc[k] < 8'd48);
            e.so  = (k == 0);
            sb.push_back(e);
            step(r1, r2, pc[k], pv[k], k == 0);
            if (quiet && k < H) check("dv_before_lock", 32'(dout_dv), 32'h0);
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dq1", 32'(dout_dq1), 32'h0);
        check("rst_dq2", 32'(dout_dq2), 32'h0);
        check("rst_dv", 32'(dout_dv), 32'h0);
        check("rst_chn", 32'(dout_chn), 32'h0);
        check("rst_sync_out", 32'(sync_out), 32'h0);
        check("rst_sync_err", 32'(sync_err), 32'h0);
        rst_n = 1'b1;
        cyc   = 0;

        // Basic transpose
        for (int k = 0; k < SIZE; k++) begin
            p1[k] = (k < H) ? 16'(16'h0100 + k) : 16'(16'h0200 + k - H);
            p2[k] = (k < H) ? 16'(16'h0110 + k) : 16'(16'h0210 + k - H);
            pc[k] = 8'(k);
            pv[k] = 1'b1;
        end
        run_period(1'b1);
        flush(SIZE);

        // Round trip: random data, channels 0..55, occasional dv=0 slots
        for (int p = 0; p < 7; p++) begin
            for (int k = 0; k < SIZE; k++) begin
                p1[k] = 16'($urandom);
                p2[k] = 16'($urandom);
                pc[k] = 8'(p * SIZE + k);
                pv[k] = ($urandom_range(0, 5) != 0);
            end
            run_period(1'b0);
        end
        flush(SIZE);
        check("no_err_after_legal_syncs", 32'(sync_err), 32'h0);

        // Channel gate 44..51
        for (int k = 0; k < SIZE; k++) begin
            p1[k] = 16'($urandom);
            p2[k] = 16'($urandom);
            pc[k] = 8'(44 + k);
            pv[k] = 1'b1;
        end
        run_period(1'b0);
        flush(SIZE);

        // Sync slip: sync at rel 0 and rel 10 (ph=2)
        for (int i = 0; i < 20; i++) begin
            step(16'(16'h1000 + i), 16'(16'h2000 + i), 8'(i), 1'b1, (i == 0) || (i == 10));
            if (i == 4)  check("slip_sync_out_5", 32'(sync_out), 32'h1);
            if (i == 9)  check("slip_err_before", 32'(sync_err), 32'h0);
            if (i == 10) check("slip_err_set", 32'(sync_err), 32'h1);
            if (i == 12) check("slip_realigned_dq2", 32'(dout_dq2), 32'h2008);
            if (i == 14) check("slip_sync_out_15", 32'(sync_out), 32'h1);
            if (i == 19) check("slip_err_sticky", 32'(sync_err), 32'h1);
        end

        // Reset mid-stream
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_dq1", 32'(dout_dq1), 32'h0);
        check("mid_rst_dq2", 32'(dout_dq2), 32'h0);
        check("mid_rst_dv", 32'(dout_dv), 32'h0);
        check("mid_rst_chn", 32'(dout_chn), 32'h0);
        check("mid_rst_sync_out", 32'(sync_out), 32'h0);
        check("mid_rst_sync_err", 32'(sync_err), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pre-sync: dv=1, legal channels, no sync
        for (int i = 0; i < 50; i++) begin
            step(16'($urandom), 16'($urandom), 8'(i % 48), 1'b1, 1'b0);
            check("presync_dv", 32'(dout_dv), 32'h0);
            check("presync_err", 32'(sync_err), 32'h0);
        end

        // First synced period after reset
        for (int k = 0; k < SIZE; k++) begin
            p1[k] = 16'($urandom);
            p2[k] = 16'($urandom);
            pc[k] = 8'(k + 8);
            pv[k] = 1'b1;
        end
        run_period(1'b1);
        flush(SIZE);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
